// File: rtl/victim_cache_ctrl.sv
// victim_cache_ctrl
// Controller for the data-cache victim buffer. It keeps tag/valid/dirty state
// for a small fully-associative victim store and drives the external victim
// data RAM (index plus read/write strobes). It answers dcache lookups, swaps a
// victim hit back into the dcache, and inserts evicted lines with FIFO
// replacement. Dirty victims are written back to memory before they are
// overwritten, and on flush.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   lookup_req_i/addr_i      lookup command and line address
//   lookup_done_o            one-cycle pulse, lookup result valid
//   victim_hit_o/hit_dirty_o/hit_idx_o  lookup result
//   swap_req_i/swap_idx_i    swap an entry with the evicted dcache line
//   ins_req_i                insert the evicted dcache line
//   ev_valid_i/ev_dirty_i/ev_addr_i     evicted line state
//   flush_req_i              write back all dirty entries, then invalidate all
//   ready_o                  high only while idle
//   op_ack_o, flush_done_o   completion pulses
//   vram_idx_o/rd_o/wr_o     victim data RAM control (1-cycle read latency)
//   vc2mem_req_o/addr_o      writeback request, held until mem2vc_ack_i
//   mem2vc_ack_i             memory accepted the writeback
module victim_cache_ctrl #(
  parameter int VC_ENTRIES  = 4,
  parameter int LINE_ADDR_W = 28,
  parameter int IDX_W       = $clog2(VC_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lookup_req_i,
  input  logic [LINE_ADDR_W-1:0] lookup_addr_i,
  output logic                   lookup_done_o,
  output logic                   victim_hit_o,
  output logic                   hit_dirty_o,
  output logic [IDX_W-1:0]       hit_idx_o,
  input  logic                   swap_req_i,
  input  logic [IDX_W-1:0]       swap_idx_i,
  input  logic                   ins_req_i,
  input  logic                   ev_valid_i,
  input  logic                   ev_dirty_i,
  input  logic [LINE_ADDR_W-1:0] ev_addr_i,
  input  logic                   flush_req_i,
  output logic                   ready_o,
  output logic                   op_ack_o,
  output logic                   flush_done_o,
  output logic [IDX_W-1:0]       vram_idx_o,
  output logic                   vram_rd_o,
  output logic                   vram_wr_o,
  output logic                   vc2mem_req_o,
  output logic [LINE_ADDR_W-1:0] vc2mem_addr_o,
  input  logic                   mem2vc_ack_i
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOOKUP    = 4'd1,
    SWAP_RD   = 4'd2,
    SWAP_WR   = 4'd3,
    INS_CHK   = 4'd4,
    DRAIN_RD  = 4'd5,
    DRAIN_REQ = 4'd6,
    INS_WR    = 4'd7,
    FL_SCAN   = 4'd8,
    FL_DONE   = 4'd9
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VC_ENTRIES - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_t                   state_r;
  logic [LINE_ADDR_W-1:0]   tag_r [VC_ENTRIES];
  logic [VC_ENTRIES-1:0]    valid_r;
  logic [VC_ENTRIES-1:0]    dirty_r;
  logic [IDX_W-1:0]         ptr_r;
  // Swap target, drain target or flush scan position, depending on the op.
  logic [IDX_W-1:0]         op_idx_r;
  logic [LINE_ADDR_W-1:0]   ev_addr_r;
  logic                     ev_valid_r;
  logic                     ev_dirty_r;
  // Distinguishes a flush drain (resume scan) from an insert drain (write).
  logic                     flush_mode_r;

  logic [VC_ENTRIES-1:0]    match_s;
  logic [IDX_W-1:0]         hit_idx_s;
  logic                     hit_dirty_s;

  // Associative tag compare; at most one valid entry can match, so OR-ing
  // the masked indices yields the one-hot encoder result (0 on a miss).
  always_comb begin
    match_s   = '0;
    hit_idx_s = '0;
    for (int i = 0; i < VC_ENTRIES; i++) begin
      match_s[i] = valid_r[i] && (tag_r[i] == lookup_addr_i);
      hit_idx_s  = hit_idx_s | (IDX_W'(i) & {IDX_W{match_s[i]}});
    end
    hit_dirty_s = |(match_s & dirty_r);
  end

  // Control FSM with registered outputs; every output is set on the edge
  // that enters the state in which it is meant to be seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      valid_r       <= '0;
      dirty_r       <= '0;
      ptr_r         <= '0;
      op_idx_r      <= '0;
      ev_addr_r     <= '0;
      ev_valid_r    <= 1'b0;
      ev_dirty_r    <= 1'b0;
      flush_mode_r  <= 1'b0;
      lookup_done_o <= 1'b0;
      victim_hit_o  <= 1'b0;
      hit_dirty_o   <= 1'b0;
      hit_idx_o     <= '0;
      ready_o       <= 1'b1;
      op_ack_o      <= 1'b0;
      flush_done_o  <= 1'b0;
      vram_idx_o    <= '0;
      vram_rd_o     <= 1'b0;
      vram_wr_o     <= 1'b0;
      vc2mem_req_o  <= 1'b0;
      vc2mem_addr_o <= '0;
    end else begin
      lookup_done_o <= 1'b0;
      op_ack_o      <= 1'b0;
      flush_done_o  <= 1'b0;
      vram_rd_o     <= 1'b0;
      vram_wr_o     <= 1'b0;
      ready_o       <= 1'b0;

      case (state_r)
        IDLE: begin
          if (flush_req_i) begin
            state_r      <= FL_SCAN;
            flush_mode_r <= 1'b1;
            op_idx_r     <= '0;
          end else if (swap_req_i) begin
            state_r    <= SWAP_RD;
            op_idx_r   <= swap_idx_i;
            ev_valid_r <= ev_valid_i;
            ev_dirty_r <= ev_dirty_i;
            ev_addr_r  <= ev_addr_i;
            vram_rd_o  <= 1'b1;
            vram_idx_o <= swap_idx_i;
          end else if (ins_req_i) begin
            state_r      <= INS_CHK;
            flush_mode_r <= 1'b0;
            ev_valid_r   <= ev_valid_i;
            ev_dirty_r   <= ev_dirty_i;
            ev_addr_r    <= ev_addr_i;
            // Nothing to insert: acknowledge while passing through INS_CHK.
            op_ack_o     <= ~ev_valid_i;
          end else if (lookup_req_i) begin
            state_r       <= LOOKUP;
            lookup_done_o <= 1'b1;
            victim_hit_o  <= |match_s;
            hit_dirty_o   <= hit_dirty_s;
            hit_idx_o     <= hit_idx_s;
          end else begin
            state_r <= IDLE;
            ready_o <= 1'b1;
          end
        end

        LOOKUP: begin
          state_r <= IDLE;
          ready_o <= 1'b1;
        end

        SWAP_RD: begin
          state_r   <= SWAP_WR;
          vram_wr_o <= ev_valid_r;
          op_ack_o  <= 1'b1;
        end

        SWAP_WR: begin
          state_r <= IDLE;
          ready_o <= 1'b1;
          if (ev_valid_r) begin
            tag_r[op_idx_r]   <= ev_addr_r;
            valid_r[op_idx_r] <= 1'b1;
            dirty_r[op_idx_r] <= ev_dirty_r;
          end else begin
            valid_r[op_idx_r] <= 1'b0;
            dirty_r[op_idx_r] <= 1'b0;
          end
        end

        INS_CHK: begin
          if (!ev_valid_r) begin
            state_r <= IDLE;
            ready_o <= 1'b1;
          end else if (valid_r[ptr_r] && dirty_r[ptr_r]) begin
            state_r    <= DRAIN_RD;
            op_idx_r   <= ptr_r;
            vram_rd_o  <= 1'b1;
            vram_idx_o <= ptr_r;
          end else begin
            state_r    <= INS_WR;
            vram_wr_o  <= 1'b1;
            vram_idx_o <= ptr_r;
            op_ack_o   <= 1'b1;
          end
        end

        DRAIN_RD: begin
          state_r       <= DRAIN_REQ;
          vc2mem_req_o  <= 1'b1;
          vc2mem_addr_o <= tag_r[op_idx_r];
        end

        DRAIN_REQ: begin
          if (mem2vc_ack_i) begin
            vc2mem_req_o <= 1'b0;
            if (!flush_mode_r) begin
              state_r    <= INS_WR;
              vram_wr_o  <= 1'b1;
              vram_idx_o <= ptr_r;
              op_ack_o   <= 1'b1;
            end else if (op_idx_r == LAST_IDX) begin
              state_r      <= FL_DONE;
              flush_done_o <= 1'b1;
            end else begin
              state_r  <= FL_SCAN;
              op_idx_r <= op_idx_r + ONE_IDX;
            end
          end else begin
            state_r <= DRAIN_REQ;
          end
        end

        INS_WR: begin
          state_r        <= IDLE;
          ready_o        <= 1'b1;
          tag_r[ptr_r]   <= ev_addr_r;
          valid_r[ptr_r] <= 1'b1;
          dirty_r[ptr_r] <= ev_dirty_r;
          // Power-of-two depth: natural overflow gives the FIFO wrap.
          ptr_r          <= ptr_r + ONE_IDX;
        end

        FL_SCAN: begin
          if (valid_r[op_idx_r] && dirty_r[op_idx_r]) begin
            state_r    <= DRAIN_RD;
            vram_rd_o  <= 1'b1;
            vram_idx_o <= op_idx_r;
          end else if (op_idx_r == LAST_IDX) begin
            state_r      <= FL_DONE;
            flush_done_o <= 1'b1;
          end else begin
            state_r  <= FL_SCAN;
            op_idx_r <= op_idx_r + ONE_IDX;
          end
        end

        FL_DONE: begin
          state_r      <= IDLE;
          ready_o      <= 1'b1;
          valid_r      <= '0;
          dirty_r      <= '0;
          ptr_r        <= '0;
          flush_mode_r <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
module tb_victim_cache_ctrl;
  localparam int N  = 4;
  localparam int AW = 28;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          lookup_req;
  logic [AW-1:0] lookup_addr;
  logic          lookup_done_o, victim_hit_o, hit_dirty_o;
  logic [IW-1:0] hit_idx_o;
  logic          swap_req;
  logic [IW-1:0] swap_idx;
  logic          ins_req, ev_valid, ev_dirty;
  logic [AW-1:0] ev_addr;
  logic          flush_req;
  logic          ready_o, op_ack_o, flush_done_o;
  logic [IW-1:0] vram_idx_o;
  logic          vram_rd_o, vram_wr_o, vc2mem_req_o;
  logic [AW-1:0] vc2mem_addr_o;
  logic          mem2vc_ack;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays describing the buffer contents.
  logic [AW-1:0] m_tag   [N];
  logic          m_valid [N];
  logic          m_dirty [N];
  int            m_ptr;

  always #5 clk = ~clk;

  victim_cache_ctrl #(.VC_ENTRIES(N), .LINE_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .lookup_req_i(lookup_req), .lookup_addr_i(lookup_addr),
    .lookup_done_o(lookup_done_o), .victim_hit_o(victim_hit_o),
    .hit_dirty_o(hit_dirty_o), .hit_idx_o(hit_idx_o),
    .swap_req_i(swap_req), .swap_idx_i(swap_idx),
    .ins_req_i(ins_req), .ev_valid_i(ev_valid), .ev_dirty_i(ev_dirty),
    .ev_addr_i(ev_addr), .flush_req_i(flush_req),
    .ready_o(ready_o), .op_ack_o(op_ack_o), .flush_done_o(flush_done_o),
    .vram_idx_o(vram_idx_o), .vram_rd_o(vram_rd_o), .vram_wr_o(vram_wr_o),
    .vc2mem_req_o(vc2mem_req_o), .vc2mem_addr_o(vc2mem_addr_o),
    .mem2vc_ack_i(mem2vc_ack)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find(input logic [AW-1:0] a);
    int r = -1;
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_tag[i] == a) r = i;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_ptr = 0;
  endtask

  task automatic idle_inputs();
    lookup_req = 1'b0; swap_req = 1'b0; ins_req = 1'b0; flush_req = 1'b0;
    ev_valid = 1'b0; ev_dirty = 1'b0;
  endtask

  task automatic do_lookup(input logic [AW-1:0] a);
    int e;
    e = find(a);
    @(negedge clk); lookup_req = 1'b1; lookup_addr = a;
    @(negedge clk); idle_inputs();
    chk1("lk_done", lookup_done_o, 1'b1);
    chk1("lk_busy", ready_o, 1'b0);
    chk1("lk_hit", victim_hit_o, e >= 0);
    chk1("lk_dirty", hit_dirty_o, (e >= 0) ? m_dirty[e] : 1'b0);
    chkw("lk_idx", AW'(hit_idx_o), (e >= 0) ? AW'(e) : '0);
    @(negedge clk);
    chk1("lk_ready", ready_o, 1'b1);
    chk1("lk_done_clr", lookup_done_o, 1'b0);
  endtask

  task automatic do_insert(input logic evv, input logic evd, input logic [AW-1:0] a, input int ack_wait);
    int   p;
    logic drain;
    p     = m_ptr;
    drain = evv && m_valid[p] && m_dirty[p];
    @(negedge clk); ins_req = 1'b1; ev_valid = evv; ev_dirty = evd; ev_addr = a;
    @(negedge clk); idle_inputs();
    if (!evv) begin
      chk1("ins_nv_ack", op_ack_o, 1'b1);
      chk1("ins_nv_wr", vram_wr_o, 1'b0);
    end else begin
      chk1("ins_c1_ack", op_ack_o, 1'b0);
      @(negedge clk);
      if (drain) begin
        chk1("drain_rd", vram_rd_o, 1'b1);
        chkw("drain_rd_idx", AW'(vram_idx_o), AW'(p));
        for (int k = 0; k < ack_wait; k++) begin
          @(negedge clk);
          chk1("drain_req", vc2mem_req_o, 1'b1);
          chkw("drain_addr", vc2mem_addr_o, m_tag[p]);
          chk1("drain_no_ack", op_ack_o, 1'b0);
          if (k == ack_wait - 1) mem2vc_ack = 1'b1;
        end
        @(negedge clk); mem2vc_ack = 1'b0;
        chk1("drain_req_drop", vc2mem_req_o, 1'b0);
      end
      chk1("ins_ack", op_ack_o, 1'b1);
      chk1("ins_wr", vram_wr_o, 1'b1);
      chkw("ins_idx", AW'(vram_idx_o), AW'(p));
      m_tag[p] = a; m_valid[p] = 1'b1; m_dirty[p] = evd;
      m_ptr = (p + 1) % N;
    end
    @(negedge clk);
    chk1("ins_ready", ready_o, 1'b1);
    chk1("ins_ack_clr", op_ack_o, 1'b0);
  endtask

  task automatic do_swap(input int idx, input logic evv, input logic evd, input logic [AW-1:0] a);
    @(negedge clk); swap_req = 1'b1; swap_idx = IW'(idx); ev_valid = evv; ev_dirty = evd; ev_addr = a;
    @(negedge clk); idle_inputs();
    chk1("sw_rd", vram_rd_o, 1'b1);
    chkw("sw_rd_idx", AW'(vram_idx_o), AW'(idx));
    chk1("sw_c1_ack", op_ack_o, 1'b0);
    @(negedge clk);
    chk1("sw_wr", vram_wr_o, evv);
    chk1("sw_ack", op_ack_o, 1'b1);
    chkw("sw_wr_idx", AW'(vram_idx_o), AW'(idx));
    if (evv) begin
      m_tag[idx] = a; m_valid[idx] = 1'b1; m_dirty[idx] = evd;
    end else begin
      m_valid[idx] = 1'b0; m_dirty[idx] = 1'b0;
    end
    @(negedge clk);
    chk1("sw_ready", ready_o, 1'b1);
  endtask

  task automatic do_flush(input int ack_wait, input logic others);
    @(negedge clk); flush_req = 1'b1;
    if (others) begin
      swap_req = 1'b1; swap_idx = 2'd1; ev_valid = 1'b1; ev_addr = 28'h0FFFFFF;
      lookup_req = 1'b1; lookup_addr = m_tag[0];
    end
    @(negedge clk); idle_inputs();
    for (int i = 0; i < N; i++) begin
      chk1("fl_busy", ready_o, 1'b0);
      chk1("fl_no_done", flush_done_o, 1'b0);
      chk1("fl_no_lookup", lookup_done_o, 1'b0);
      chk1("fl_no_ack", op_ack_o, 1'b0);
      chk1("fl_no_req", vc2mem_req_o, 1'b0);
      if (m_valid[i] && m_dirty[i]) begin
        @(negedge clk);
        chk1("fl_rd", vram_rd_o, 1'b1);
        chkw("fl_rd_idx", AW'(vram_idx_o), AW'(i));
        for (int k = 0; k < ack_wait; k++) begin
          @(negedge clk);
          chk1("fl_req", vc2mem_req_o, 1'b1);
          chkw("fl_addr", vc2mem_addr_o, m_tag[i]);
          if (k == ack_wait - 1) mem2vc_ack = 1'b1;
        end
        @(negedge clk); mem2vc_ack = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    chk1("fl_done", flush_done_o, 1'b1);
    model_clear();
    @(negedge clk);
    chk1("fl_ready", ready_o, 1'b1);
    chk1("fl_done_clr", flush_done_o, 1'b0);
  endtask

  initial begin
    rst = 1'b1; mem2vc_ack = 1'b0; lookup_addr = '0; swap_idx = '0; ev_addr = '0;
    idle_inputs();
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Reset state
    chk1("rst_ready", ready_o, 1'b1);
    chk1("rst_req", vc2mem_req_o, 1'b0);
    chk1("rst_ack", op_ack_o, 1'b0);
    chk1("rst_fdone", flush_done_o, 1'b0);
    chk1("rst_ldone", lookup_done_o, 1'b0);
    chk1("rst_rd", vram_rd_o, 1'b0);
    chk1("rst_wr", vram_wr_o, 1'b0);

    // Miss, insert, hit
    do_lookup(28'h0000010);
    do_insert(1'b1, 1'b0, 28'h0000010, 1);
    do_lookup(28'h0000010);

    // Clean flush (latency N+1), then fill with dirty lines and replace FIFO-wise
    do_flush(1, 1'b0);
    for (int i = 0; i < N; i++) do_insert(1'b1, 1'b1, 28'h0A00000 + AW'(i), 1);
    do_insert(1'b1, 1'b0, 28'h0A00004, 3);
    do_insert(1'b1, 1'b1, 28'h0A00005, 1);
    do_lookup(28'h0A00000);
    do_lookup(28'h0A00004);

    // Swap idx 2 (line A2) with clean B, then swap it out with no evicted line
    do_swap(2, 1'b1, 1'b0, 28'h0B00000);
    do_lookup(28'h0B00000);
    do_lookup(28'h0A00002);
    do_swap(2, 1'b0, 1'b0, 28'h0000000);
    do_lookup(28'h0B00000);
    do_insert(1'b0, 1'b0, 28'h0C00000, 1);
    do_insert(1'b1, 1'b1, 28'h0C00001, 1);

    // Simultaneous flush/swap/lookup: flush wins and drains in index order
    do_flush(2, 1'b1);
    do_lookup(28'h0A00003);

    // Reset while a writeback request is outstanding
    for (int i = 0; i < N; i++) do_insert(1'b1, 1'b1, 28'h0D00000 + AW'(i), 1);
    @(negedge clk); ins_req = 1'b1; ev_valid = 1'b1; ev_dirty = 1'b0; ev_addr = 28'h0D00010;
    @(negedge clk); idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk1("rr_req_before", vc2mem_req_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk1("rr_req_drop", vc2mem_req_o, 1'b0);
    chk1("rr_no_ack", op_ack_o, 1'b0);
    rst = 1'b0; mem2vc_ack = 1'b1;
    model_clear();
    @(negedge clk); mem2vc_ack = 1'b0;
    chk1("rr_ready", ready_o, 1'b1);
    chk1("rr_ign_ack", op_ack_o, 1'b0);
    chk1("rr_ign_req", vc2mem_req_o, 1'b0);
    do_lookup(28'h0D00000);
    do_lookup(28'h0D00003);
    do_insert(1'b1, 1'b0, 28'h0D00020, 1);

    // Randomised mix against the model
    for (int it = 0; it < 120; it++) begin
      int            op;
      logic [AW-1:0] a;
      op = int'($urandom_range(0, 12));
      a  = 28'h0E00000 + AW'($urandom_range(0, 9));
      if (op <= 4) begin
        do_lookup(a);
      end else if (op <= 8) begin
        if (find(a) >= 0) do_lookup(a);
        else do_insert($urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1, a,
                       int'($urandom_range(1, 3)));
      end else if (op <= 11) begin
        if (find(a) >= 0) do_lookup(a);
        else do_swap(int'($urandom_range(0, N - 1)), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 1) == 1, a);
      end else begin
        do_flush(int'($urandom_range(1, 3)), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/victim_cache_ctrl.md
# victim_cache_ctrl

Controller for the data-cache victim buffer. It holds the tag, valid and dirty state for a small fully-associative victim store and drives the external victim data RAM with index and read/write strobes. It answers lookups from the dcache controller, swaps a victim hit back into the dcache, and inserts evicted lines with FIFO replacement. Dirty victims are drained to data memory before they are overwritten, and on flush.

## Interface

Parameters:
- `VC_ENTRIES`, 4: number of victim entries; power of two, ≥2.
- `LINE_ADDR_W`, 28: line-address width (byte address minus line offset).
- `IDX_W`, $clog2(VC_ENTRIES): entry index width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `lookup_req_i`  in  1  lookup request, sampled in IDLE.
- `lookup_addr_i`  in  LINE_ADDR_W  line address to look up.
- `lookup_done_o`  out  1  one-cycle pulse; lookup result is valid.
- `victim_hit_o`  out  1  a lookup hit; valid with `lookup_done_o`.
- `hit_dirty_o`  out  1  dirty bit of the hit entry.
- `hit_idx_o`  out  IDX_W  index of the hit entry.
- `swap_req_i`  in  1  swap the entry at `swap_idx_i` with the evicted dcache line.
- `swap_idx_i`  in  IDX_W  entry to swap out.
- `ins_req_i`  in  1  insert the evicted dcache line.
- `ev_valid_i`, `ev_dirty_i`  in  1 each  evicted line state.
- `ev_addr_i`  in  LINE_ADDR_W  evicted line address.
- `flush_req_i`  in  1  drain all dirty entries, then invalidate all entries.
- `ready_o`  out  1  high only in IDLE.
- `op_ack_o`  out  1  one-cycle pulse; swap or insert complete.
- `flush_done_o`  out  1  one-cycle pulse; flush complete.
- `vram_idx_o`  out  IDX_W  data RAM index.
- `vram_rd_o`, `vram_wr_o`  out  1 each  data RAM strobes. The RAM is synchronous with 1-cycle read latency and read-first behaviour.
- `vc2mem_req_o`  out  1  writeback request to data memory.
- `vc2mem_addr_o`  out  LINE_ADDR_W  writeback line address.
- `mem2vc_ack_i`  in  1  memory accepted the writeback.

## Operation

- States: IDLE, LOOKUP, SWAP_RD, SWAP_WR, INS_CHK, DRAIN_RD, DRAIN_REQ, INS_WR, FL_SCAN, FL_DONE.
- Commands are accepted only in IDLE. When several requests are high together, priority is flush > swap > insert > lookup; losing requests are ignored and must be re-presented. Input operands are registered at acceptance.
- **Lookup.**
  - Compare the address against all valid tags.
  - In LOOKUP, pulse `lookup_done_o` with `victim_hit_o`, `hit_dirty_o` and `hit_idx_o`.
  - On a miss, `hit_idx_o` = 0 and `hit_dirty_o` = 0.
  - Return to IDLE.
- **Swap.**
  - SWAP_RD: `vram_rd_o` at `swap_idx`.
  - SWAP_WR: the datapath takes the RAM read data for the dcache fill.
    - If `ev_valid`: assert `vram_wr_o` at the same index and write tag/valid/dirty from the evicted line.
    - Otherwise: clear the entry's valid bit.
  - Pulse `op_ack_o`; the FIFO pointer is unchanged.
- **Insert.**
  - If `ev_valid` = 0: pulse `op_ack_o` in INS_CHK with no state change.
  - Otherwise, in INS_CHK, test slot `ptr`:
    - Valid and dirty: go to DRAIN_RD (`vram_rd_o` at `ptr`), then DRAIN_REQ.
    - Otherwise: go to INS_WR.
  - DRAIN_REQ: hold `vc2mem_req_o` = 1 with `vc2mem_addr_o` = tag[ptr] until `mem2vc_ack_i`, then go to INS_WR.
  - INS_WR: `vram_wr_o` at `ptr`; write tag, valid = 1 and dirty = `ev_dirty`; `ptr` ← `ptr` + 1 mod `VC_ENTRIES`; pulse `op_ack_o`.
- **Flush.**
  - Scan the index from 0 to `VC_ENTRIES` − 1. Each valid, dirty entry goes through DRAIN_RD/DRAIN_REQ, then the scan resumes at the next index.
  - FL_DONE: clear all valid and dirty bits, `ptr` ← 0, pulse `flush_done_o`.
- Invariant: at most one valid entry matches any address. The dcache controller never inserts a line that is resident in the buffer.

## Timing

- Reset values:
  - State IDLE, `ptr` = 0, all valid and dirty bits 0.
  - All pulses, strobes and `vc2mem_req_o` are 0; `ready_o` = 1 in the first cycle after `rst` deasserts.
  - Tag contents are don't-care.
- Latencies, with acceptance at cycle 0:
  - Lookup: `lookup_done_o` at cycle 1.
  - Swap: `vram_rd_o` at cycle 1; `vram_wr_o` and `op_ack_o` at cycle 2.
  - Insert, slot clean or invalid: `op_ack_o` at cycle 2.
  - Insert, slot dirty: `vram_rd_o` at cycle 2; `vc2mem_req_o` from cycle 3; `op_ack_o` one cycle after the `mem2vc_ack_i` cycle.
- `ready_o` returns to 1 in the cycle after any ack or done pulse.
- `vc2mem_req_o` and `vc2mem_addr_o` stay stable until ack.
- `mem2vc_ack_i` is ignored outside DRAIN_REQ. Ack in the first DRAIN_REQ cycle is legal and gives a one-cycle request.
- Pointer wrap: an insert at `ptr` = `VC_ENTRIES` − 1 sets `ptr` to 0.
- Flush with no dirty entries: `flush_done_o` at cycle `VC_ENTRIES` + 1.
- `rst` asserted mid-operation: IDLE on the next edge; `vc2mem_req_o` drops immediately with no completion pulse; all entries are invalidated.

## Test plan

- **Reset, then miss/insert/hit.** Lookup 0x0000010 → miss at cycle 1. Insert clean 0x0000010 → ack at cycle 2, ptr = 1. Lookup again → hit, idx 0, dirty 0.
- **Fill and FIFO replacement.** Insert 4 dirty lines A0–A3. A fifth insert drains A0: `vc2mem_addr_o` = A0, request held for 3 cycles until ack. Then write to idx 0, ptr = 1.
- **Swap.** With the buffer holding line A2 at idx 2, swap idx 2 with a clean evicted line B → `vram_rd_o` at cycle 1, `vram_wr_o` at cycle 2, idx 2 tag = B. Swap with `ev_valid` = 0 → idx 2 invalid, ptr unchanged.
- **Simultaneous requests.** flush, swap and lookup high in the same cycle → flush executes; dirty entries drain in index order; `flush_done_o` pulses; all entries invalid.
- **Reset during DRAIN_REQ.** Assert `rst` while `vc2mem_req_o` is high → request low next cycle; a later `mem2vc_ack_i` is ignored; lookups miss.
